pid_seq: RTL and testbench

- Control-loop sequencer that sits directly upstream of the combinational ALU.
- Each iteration it requests an A2D conversion, then drives the ALU select and mode lines through a fixed schedule of math steps. It captures each ALU result into the working registers that feed back into the ALU (Error, Intgrl, Icomp, Pcomp, Accum).
- It finishes by publishing a clamped 12-bit motor command with a one-cycle done strobe.

---
 rtl/pid_pkg.sv | 84 ++++++++
 rtl/pid_seq.sv | 153 +++++++++++++++
 tb/tb_pid_seq.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pid_pkg.sv
// Shared definitions for the PID sequencer and the ALU it drives: the
// sequencer state encoding, the ALU operand-select codes and the per-state
// ALU control decode.
package pid_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CONV,
      ST_WAIT,
      ST_ERR,
      ST_INTG,
      ST_ICOMP,
      ST_PCOMP,
      ST_ACC1,
      ST_ACC2,
      ST_DONE
   } state_t;

   // ALU src0 operand selects
   localparam logic [2:0] A2D2Src0    = 3'b000;
   localparam logic [2:0] Intgrl2Src0 = 3'b001;
   localparam logic [2:0] Icomp2Src0  = 3'b010;
   localparam logic [2:0] Pcomp2Src0  = 3'b011;
   localparam logic [2:0] Pterm2Src0  = 3'b100;

   // ALU src1 operand selects
   localparam logic [2:0] Accum2Src1   = 3'b000;
   localparam logic [2:0] Iterm2Src1   = 3'b001;
   localparam logic [2:0] Err2Src1     = 3'b010;
   localparam logic [2:0] ErrDiv22Src1 = 3'b011;
   localparam logic [2:0] Fwd2Src1     = 3'b100;

   typedef struct packed {
      logic [2:0] src0sel;
      logic [2:0] src1sel;
      logic       multiply;
      logic       sub;
      logic       saturate;
   } alu_ctrl_t;

   // ALU controls that belong to each sequencer state; anything not listed
   // idles the ALU with all selects and mode flags at zero.
   function automatic alu_ctrl_t ctrl_for_state(input state_t s);
      alu_ctrl_t c;
      c = '0;
      case (s)
         ST_ERR: begin
            c.src0sel  = A2D2Src0;
            c.src1sel  = Fwd2Src1;
            c.sub      = 1'b1;
            c.saturate = 1'b1;
         end
         ST_INTG: begin
            c.src0sel  = Intgrl2Src0;
            c.src1sel  = ErrDiv22Src1;
            c.saturate = 1'b1;
         end
         ST_ICOMP: begin
            c.src0sel  = Intgrl2Src0;
            c.src1sel  = Iterm2Src1;
            c.multiply = 1'b1;
         end
         ST_PCOMP: begin
            c.src0sel  = Pterm2Src0;
            c.src1sel  = Err2Src1;
            c.multiply = 1'b1;
         end
         ST_ACC1: begin
            c.src0sel  = Pcomp2Src0;
            c.src1sel  = Fwd2Src1;
            c.sub      = 1'b1;
         end
         ST_ACC2: begin
            c.src0sel  = Icomp2Src0;
            c.src1sel  = Accum2Src1;
            c.sub      = 1'b1;
            c.saturate = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pid_seq.sv
// PID control-loop sequencer. Each iteration requests one A2D conversion,
// then walks the ALU through the error / integrator / I / P / accumulate
// schedule, capturing each result into the working registers that feed back
// into the ALU, and finally publishes a clamped 12-bit motor command.
module pid_seq
   import pid_pkg::*;
#(
   parameter logic [2:0] CHNNL         = 3'b000,
   parameter int         INTG_DECIMATE = 4,
   parameter int         MULT_CYCLES   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   output logic        strt_cnv,
   output logic [2:0]  chnnl,
   input  logic        cnv_cmplt,
   input  logic [15:0] dst,
   output logic [2:0]  src0sel,
   output logic [2:0]  src1sel,
   output logic        multiply,
   output logic        sub,
   output logic        mult2,
   output logic        mult4,
   output logic        saturate,
   output logic [11:0] Error,
   output logic [11:0] Intgrl,
   output logic [11:0] Icomp,
   output logic [15:0] Pcomp,
   output logic [15:0] Accum,
   output logic [11:0] mtr,
   output logic        done,
   output logic        busy
);

   localparam int DW = (INTG_DECIMATE > 1) ? $clog2(INTG_DECIMATE) : 1;
   localparam int MW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
   localparam logic [MW-1:0] MULT_LAST = MW'(MULT_CYCLES - 1);

   state_t        state;
   state_t        nxt;
   alu_ctrl_t     ctrl;
   alu_ctrl_t     ctrl_nxt;
   logic [DW-1:0] dec_cnt;
   logic [MW-1:0] mcnt;
   logic          mult_last;
   logic          in_mult;

   // Signed 16 -> signed 12 clamp for the motor command.
   function automatic logic [11:0] clamp12(input logic signed [15:0] v);
      if (v > 16'sd2047)
         return 12'h7FF;
      else if (v < -16'sd2048)
         return 12'h800;
      else
         return v[11:0];
   endfunction

   assign in_mult   = (state == ST_ICOMP) || (state == ST_PCOMP);
   assign mult_last = (mcnt == MULT_LAST);

   // Next-state selection for the fixed math schedule.
   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:  if (go) nxt = ST_CONV;
         ST_CONV:  nxt = ST_WAIT;
         ST_WAIT:  if (cnv_cmplt) nxt = ST_ERR;
         ST_ERR:   nxt = (dec_cnt == '0) ? ST_INTG : ST_ICOMP;
         ST_INTG:  nxt = ST_ICOMP;
         ST_ICOMP: if (mult_last) nxt = ST_PCOMP;
         ST_PCOMP: if (mult_last) nxt = ST_ACC1;
         ST_ACC1:  nxt = ST_ACC2;
         ST_ACC2:  nxt = ST_DONE;
         ST_DONE:  nxt = ST_IDLE;
         default:  nxt = ST_IDLE;
      endcase
   end

   assign ctrl_nxt = ctrl_for_state(nxt);

   // State register with registered Moore outputs decoded from the next state,
   // so every control is glitch-free and lines up with the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         ctrl     <= '0;
         strt_cnv <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= nxt;
         ctrl     <= ctrl_nxt;
         strt_cnv <= (nxt == ST_CONV);
         done     <= (nxt == ST_DONE);
      end
   end

   // Multiply hold counter: restarts on every state change, counts while a
   // multiply step holds the ALU controls.
   always_ff @(posedge clk) begin
      if (rst)
         mcnt <= '0;
      else if (nxt != state)
         mcnt <= '0;
      else if (in_mult)
         mcnt <= mcnt + 1'b1;
   end

   // Integrator decimation counter, advanced once per completed iteration.
   always_ff @(posedge clk) begin
      if (rst)
         dec_cnt <= '0;
      else if ((state == ST_DONE) && (INTG_DECIMATE > 1))
         dec_cnt <= dec_cnt + 1'b1;
   end

   // Working registers: each captures the ALU result only at the edge ending
   // its own step.
   always_ff @(posedge clk) begin
      if (rst) begin
         Error  <= '0;
         Intgrl <= '0;
         Icomp  <= '0;
         Pcomp  <= '0;
         Accum  <= '0;
         mtr    <= '0;
      end else begin
         case (state)
            ST_ERR:   Error  <= dst[11:0];
            ST_INTG:  Intgrl <= dst[11:0];
            ST_ICOMP: if (mult_last) Icomp <= dst[11:0];
            ST_PCOMP: if (mult_last) Pcomp <= dst;
            ST_ACC1:  Accum  <= dst;
            ST_ACC2: begin
               Accum <= dst;
               mtr   <= clamp12($signed(dst));
            end
            default: ;
         endcase
      end
   end

   assign src0sel  = ctrl.src0sel;
   assign src1sel  = ctrl.src1sel;
   assign multiply = ctrl.multiply;
   assign sub      = ctrl.sub;
   assign saturate = ctrl.saturate;
   assign mult2    = 1'b0;
   assign mult4    = 1'b0;
   assign chnnl    = CHNNL;
   assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_pid_seq.sv
// Directed bench for pid_seq with a small behavioural ALU model closing the
// loop on dst. Each scenario task drives stimulus and checks inline.
module tb_pid_seq;
   import pid_pkg::*;

   logic        clk = 1'b0;
   logic        rst, go, cnv_cmplt;
   logic [15:0] dst;
   logic        strt_cnv, multiply, sub, mult2, mult4, saturate, done, busy;
   logic [2:0]  chnnl, src0sel, src1sel;
   logic [11:0] Error, Intgrl, Icomp, mtr;
   logic [15:0] Pcomp, Accum;

   logic [11:0] a2d_res, fwd, pterm, iterm;
   logic        ovr_en;
   logic [15:0] ovr_val;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   pid_seq #(.CHNNL(3'b000), .INTG_DECIMATE(4), .MULT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .go(go), .strt_cnv(strt_cnv), .chnnl(chnnl),
      .cnv_cmplt(cnv_cmplt), .dst(dst), .src0sel(src0sel), .src1sel(src1sel),
      .multiply(multiply), .sub(sub), .mult2(mult2), .mult4(mult4),
      .saturate(saturate), .Error(Error), .Intgrl(Intgrl), .Icomp(Icomp),
      .Pcomp(Pcomp), .Accum(Accum), .mtr(mtr), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU: src0 - src1 (or +, or scaled product), optional 12-bit saturation.
   always_comb begin
      logic signed [15:0] s0, s1, r;
      logic signed [31:0] prod;
      s0 = '0;
      s1 = '0;
      case (src0sel)
         3'b000:  s0 = {4'h0, a2d_res};
         3'b001:  s0 = {{4{Intgrl[11]}}, Intgrl};
         3'b010:  s0 = {{4{Icomp[11]}}, Icomp};
         3'b011:  s0 = Pcomp;
         3'b100:  s0 = {{4{pterm[11]}}, pterm};
         default: s0 = '0;
      endcase
      case (src1sel)
         3'b000:  s1 = Accum;
         3'b001:  s1 = {{4{iterm[11]}}, iterm};
         3'b010:  s1 = {{4{Error[11]}}, Error};
         3'b011:  s1 = {{5{Error[11]}}, Error[11:1]};
         3'b100:  s1 = {4'h0, fwd};
         default: s1 = '0;
      endcase
      prod = s0 * s1;
      if (multiply)
         r = prod[27:12];
      else if (sub)
         r = s0 - s1;
      else
         r = s0 + s1;
      if (saturate) begin
         if (r > 16'sd2047)
            r = 16'sd2047;
         else if (r < -16'sd2048)
            r = -16'sd2048;
      end
      if (ovr_en && (src0sel == Icomp2Src0) && sub)
         dst = ovr_val;
      else
         dst = r;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One iteration: go pulse, cnv_cmplt cnv_delay cycles after strt_cnv.
   // Returns at the negedge where done is observed; lat is the done cycle
   // counted from the edge sampling cnv_cmplt (that edge's cycle = 1).
   task automatic run_iter(input int cnv_delay, output int lat, output bit tmo);
      int e;
      tmo = 1'b0;
      lat = -1;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int i = 0; i < 10 && !strt_cnv; i++) @(negedge clk);
      if (!strt_cnv) tmo = 1'b1;
      repeat (cnv_delay) @(negedge clk);
      cnv_cmplt = 1'b1;
      e = cyc + 1;
      @(negedge clk);
      cnv_cmplt = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            lat = cyc - e + 1;
            break;
         end
         @(negedge clk);
      end
      if (lat < 0) tmo = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({Error, Intgrl, Icomp} !== 36'h0) begin
         errors++;
         $display("FAIL reset_regs12: got %h required 0", {Error, Intgrl, Icomp});
      end
      checks++;
      if ({Pcomp, Accum, mtr} !== 44'h0) begin
         errors++;
         $display("FAIL reset_regs16: got %h required 0", {Pcomp, Accum, mtr});
      end
      checks++;
      if ({done, strt_cnv, busy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got %b required 000", {done, strt_cnv, busy});
      end
      checks++;
      if ({src0sel, src1sel, multiply, sub, saturate, mult2, mult4} !== 11'h0) begin
         errors++;
         $display("FAIL reset_ctrl: got %h required 0",
                  {src0sel, src1sel, multiply, sub, saturate, mult2, mult4});
      end
   endtask

   task automatic test_basic();
      int lat;
      bit tmo;
      run_iter(3, lat, tmo);
      checks++;
      if (tmo) begin
         errors++;
         $display("FAIL basic_timeout: got timeout required done");
      end
      checks++;
      if (lat !== 9) begin
         errors++;
         $display("FAIL basic_latency: got %0d required 9", lat);
      end
      checks++;
      if (Error !== 12'h080) begin
         errors++;
         $display("FAIL basic_error: got %h required 080", Error);
      end
      checks++;
      if (Intgrl !== 12'h040) begin
         errors++;
         $display("FAIL basic_intgrl: got %h required 040", Intgrl);
      end
      checks++;
      if ({Icomp, Pcomp} !== 28'h0) begin
         errors++;
         $display("FAIL basic_icomp_pcomp: got %h required 0", {Icomp, Pcomp});
      end
      checks++;
      if (Accum !== 16'h0100) begin
         errors++;
         $display("FAIL basic_accum: got %h required 0100", Accum);
      end
      checks++;
      if (mtr !== 12'h100) begin
         errors++;
         $display("FAIL basic_mtr: got %h required 100", mtr);
      end
      @(negedge clk);
      checks++;
      if ({done, busy} !== 2'b00) begin
         errors++;
         $display("FAIL basic_done_width: got done,busy=%b required 00", {done, busy});
      end
   endtask

   task automatic test_decimation();
      int lat;
      bit tmo;
      for (int it = 2; it <= 5; it++) begin
         run_iter(3, lat, tmo);
         checks++;
         if (lat !== ((it == 5) ? 9 : 8)) begin
            errors++;
            $display("FAIL decim_latency_it%0d: got %0d required %0d", it, lat,
                     (it == 5) ? 9 : 8);
         end
         checks++;
         if (Intgrl !== ((it == 5) ? 12'h080 : 12'h040)) begin
            errors++;
            $display("FAIL decim_intgrl_it%0d: got %h required %h", it, Intgrl,
                     (it == 5) ? 12'h080 : 12'h040);
         end
      end
   endtask

   task automatic test_decode();
      logic [11:0] exp_tab [10];
      logic [11:0] obs;
      // {src0sel, src1sel, multiply, sub, saturate, mult2, mult4, done}
      exp_tab[0] = {3'b000, 3'b100, 1'b0, 1'b1, 1'b1, 3'b000};
      exp_tab[1] = {3'b001, 3'b011, 1'b0, 1'b0, 1'b1, 3'b000};
      exp_tab[2] = {3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 3'b000};
      exp_tab[3] = {3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 3'b000};
      exp_tab[4] = {3'b100, 3'b010, 1'b1, 1'b0, 1'b0, 3'b000};
      exp_tab[5] = {3'b100, 3'b010, 1'b1, 1'b0, 1'b0, 3'b000};
      exp_tab[6] = {3'b011, 3'b100, 1'b0, 1'b1, 1'b0, 3'b000};
      exp_tab[7] = {3'b010, 3'b000, 1'b0, 1'b1, 1'b1, 3'b000};
      exp_tab[8] = {3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001};
      exp_tab[9] = 12'h000;
      do_reset();
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      obs = {src0sel, src1sel, multiply, sub, saturate, mult2, mult4, done};
      checks++;
      if ({strt_cnv, busy, obs} !== {2'b11, 12'h000}) begin
         errors++;
         $display("FAIL decode_conv: got %h required %h", {strt_cnv, busy, obs},
                  {2'b11, 12'h000});
      end
      repeat (2) @(negedge clk);
      obs = {src0sel, src1sel, multiply, sub, saturate, mult2, mult4, done};
      checks++;
      if ({strt_cnv, busy, obs} !== {2'b01, 12'h000}) begin
         errors++;
         $display("FAIL decode_wait: got %h required %h", {strt_cnv, busy, obs},
                  {2'b01, 12'h000});
      end
      cnv_cmplt = 1'b1;
      @(negedge clk);
      cnv_cmplt = 1'b0;
      for (int s = 0; s < 10; s++) begin
         obs = {src0sel, src1sel, multiply, sub, saturate, mult2, mult4, done};
         checks++;
         if (obs !== exp_tab[s]) begin
            errors++;
            $display("FAIL decode_step%0d: got %h required %h", s, obs, exp_tab[s]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_handshake();
      int pulses;
      int lat;
      int extra;
      pulses = 0;
      extra  = 0;
      lat    = -1;
      @(negedge clk);
      go = 1'b1;
      for (int i = 0; i < 55; i++) begin
         @(negedge clk);
         if (strt_cnv) begin
            pulses++;
            checks++;
            if (chnnl !== 3'b000) begin
               errors++;
               $display("FAIL hs_chnnl: got %b required 000", chnnl);
            end
         end
         go = i[0];
      end
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("FAIL hs_strt_cnv_count: got %0d required 1", pulses);
      end
      checks++;
      if ({busy, src0sel, src1sel, multiply, sub, saturate} !== {1'b1, 9'h0}) begin
         errors++;
         $display("FAIL hs_wait_hold: got %h required %h",
                  {busy, src0sel, src1sel, multiply, sub, saturate}, {1'b1, 9'h0});
      end
      go = 1'b1;
      cnv_cmplt = 1'b1;
      @(negedge clk);
      cnv_cmplt = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (lat < 0) begin
         errors++;
         $display("FAIL hs_done: got no done required done within 40 cycles");
      end
      @(negedge clk);
      go = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (strt_cnv || busy) extra++;
         @(negedge clk);
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL hs_no_extra_iter: got %0d busy cycles required 0", extra);
      end
   endtask

   task automatic test_clamp();
      logic [15:0] vals [3];
      logic [11:0] exps [3];
      int lat;
      bit tmo;
      vals = '{16'h1234, 16'hE000, 16'hFFFE};
      exps = '{12'h7FF, 12'h800, 12'hFFE};
      for (int k = 0; k < 3; k++) begin
         ovr_en  = 1'b1;
         ovr_val = vals[k];
         run_iter(3, lat, tmo);
         ovr_en = 1'b0;
         checks++;
         if (mtr !== exps[k]) begin
            errors++;
            $display("FAIL clamp_mtr_%h: got %h required %h", vals[k], mtr, exps[k]);
         end
         checks++;
         if (Accum !== vals[k]) begin
            errors++;
            $display("FAIL clamp_accum_%h: got %h required %h", vals[k], Accum, vals[k]);
         end
      end
   endtask

   task automatic test_reset_midop();
      int lat;
      bit tmo;
      bit seen;
      do_reset();
      run_iter(3, lat, tmo);
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (3) @(negedge clk);
      cnv_cmplt = 1'b1;
      @(negedge clk);
      cnv_cmplt = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (multiply) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (!seen || multiply !== 1'b1) begin
         errors++;
         $display("FAIL midop_second_icomp: got multiply=%b required 1", multiply);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({Error, Intgrl, Icomp, Pcomp, Accum, mtr} !== 80'h0) begin
         errors++;
         $display("FAIL midop_regs: got %h required 0",
                  {Error, Intgrl, Icomp, Pcomp, Accum, mtr});
      end
      checks++;
      if ({done, strt_cnv, busy} !== 3'b000) begin
         errors++;
         $display("FAIL midop_flags: got %b required 000", {done, strt_cnv, busy});
      end
      checks++;
      if ({src0sel, src1sel, multiply, sub, saturate, mult2, mult4} !== 11'h0) begin
         errors++;
         $display("FAIL midop_ctrl: got %h required 0",
                  {src0sel, src1sel, multiply, sub, saturate, mult2, mult4});
      end
      run_iter(3, lat, tmo);
      checks++;
      if (lat !== 9) begin
         errors++;
         $display("FAIL midop_after_latency: got %0d required 9", lat);
      end
      checks++;
      if ({Intgrl, mtr} !== {12'h040, 12'h100}) begin
         errors++;
         $display("FAIL midop_after_regs: got %h required %h", {Intgrl, mtr},
                  {12'h040, 12'h100});
      end
   endtask

   initial begin
      rst       = 1'b1;
      go        = 1'b0;
      cnv_cmplt = 1'b0;
      ovr_en    = 1'b0;
      ovr_val   = 16'h0;
      a2d_res   = 12'h180;
      fwd       = 12'h100;
      pterm     = 12'h000;
      iterm     = 12'h000;
      test_reset();
      test_basic();
      test_decimation();
      test_decode();
      test_handshake();
      test_clamp();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
